// File: rtl/decode_stage_if.sv
// Bundle of the decode-stage signals: fetch register inputs, writeback port,
// pipeline control and the D/E pipeline register outputs.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic [31:0]     instr_d;
  logic [31:0]     pc_d;
  logic            stall_in;
  logic            flush;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall_fd;
  logic            valid_e;
  logic [31:0]     pc_e;
  logic [XLEN-1:0] rs1_val_e;
  logic [XLEN-1:0] rs2_val_e;
  logic [XLEN-1:0] imm_e;
  logic [4:0]      rd_e;
  logic [3:0]      alu_op_e;
  logic [7:0]      ctrl_e;
  logic            illegal_e;

  modport slave (
    input  instr_d, pc_d, stall_in, flush, wb_we, wb_rd, wb_data,
    output stall_fd, valid_e, pc_e, rs1_val_e, rs2_val_e, imm_e, rd_e,
           alu_op_e, ctrl_e, illegal_e
  );

  modport master (
    output instr_d, pc_d, stall_in, flush, wb_we, wb_rd, wb_data,
    input  stall_fd, valid_e, pc_e, rs1_val_e, rs2_val_e, imm_e, rd_e,
           alu_op_e, ctrl_e, illegal_e
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through bypass, immediate and
// control generation, load-use hazard detection and the D/E pipeline register.
module decode_stage #(
  parameter int          XLEN       = 32,
  parameter int          NREGS      = 32,
  parameter logic [31:0] RST_VECTOR = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] regs [NREGS];
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic [31:0]     imm32;
  logic [7:0]      ctrl;
  logic [3:0]      alu_op;
  logic            illegal, use_rs1, use_rs2, hz, wb_hit;

  assign instr  = bus.instr_d;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign wb_hit = bus.wb_we && (bus.wb_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst && wb_hit) regs[bus.wb_rd] <= bus.wb_data;
  end

  // A value written back this cycle is forwarded straight into the read.
  assign rs1_val = (rs1 == 5'd0) ? '0 : (wb_hit && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : (wb_hit && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2];

  // ctrl = {reg_we, mem_rd, mem_wr, branch, jal, jalr, lui, auipc}
  always_comb begin
    ctrl    = '0;
    imm32   = '0;
    alu_op  = '0;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (instr != 32'h0) begin
      case (opcode)
        OP_LUI: begin
          ctrl  = 8'b1000_0010;
          imm32 = {instr[31:12], 12'b0};
        end
        OP_AUIPC: begin
          ctrl  = 8'b1000_0001;
          imm32 = {instr[31:12], 12'b0};
        end
        OP_JAL: begin
          ctrl  = 8'b1000_1000;
          imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OP_JALR: begin
          ctrl    = 8'b1000_0100;
          imm32   = {{20{instr[31]}}, instr[31:20]};
          use_rs1 = 1'b1;
        end
        OP_BRANCH: begin
          ctrl    = 8'b0001_0000;
          imm32   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        OP_LOAD: begin
          ctrl    = 8'b1100_0000;
          imm32   = {{20{instr[31]}}, instr[31:20]};
          use_rs1 = 1'b1;
        end
        OP_STORE: begin
          ctrl    = 8'b0010_0000;
          imm32   = {{21{instr[31]}}, instr[30:25], instr[11:7]};
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        OP_IMM: begin
          ctrl    = 8'b1000_0000;
          imm32   = {{20{instr[31]}}, instr[31:20]};
          alu_op  = {instr[30], instr[14:12]};
          use_rs1 = 1'b1;
        end
        OP_REG: begin
          ctrl    = 8'b1000_0000;
          alu_op  = {instr[30], instr[14:12]};
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        OP_FENCE, OP_SYSTEM: imm32 = {{20{instr[31]}}, instr[31:20]};
        default: illegal = 1'b1;
      endcase
    end
  end

  assign imm = XLEN'($signed(imm32));

  assign hz = bus.valid_e && bus.ctrl_e[6] && (bus.rd_e != 5'd0) &&
              ((use_rs1 && bus.rd_e == rs1) || (use_rs2 && bus.rd_e == rs2));
  assign bus.stall_fd = (hz || bus.stall_in) && !bus.flush;

  // Flush and load-use both leave a bubble; only a plain advance loads new fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_e   <= 1'b0;
      bus.pc_e      <= RST_VECTOR;
      bus.rs1_val_e <= '0;
      bus.rs2_val_e <= '0;
      bus.imm_e     <= '0;
      bus.rd_e      <= '0;
      bus.alu_op_e  <= '0;
      bus.ctrl_e    <= '0;
      bus.illegal_e <= 1'b0;
    end else if (bus.flush || (!bus.stall_in && hz)) begin
      bus.valid_e   <= 1'b0;
      bus.ctrl_e    <= '0;
      bus.illegal_e <= 1'b0;
    end else if (!bus.stall_in) begin
      bus.valid_e   <= (instr != 32'h0);
      bus.pc_e      <= bus.pc_d;
      bus.rs1_val_e <= rs1_val;
      bus.rs2_val_e <= rs2_val;
      bus.imm_e     <= imm;
      bus.rd_e      <= rd;
      bus.alu_op_e  <= alu_op;
      bus.ctrl_e    <= ctrl;
      bus.illegal_e <= illegal;
    end
  end
endmodule
